// File: rtl/axi_wr_pkg.sv
// Shared types and constants for the AXI write router.
// Contents: FSM state enum, B-response codes, one-hot slave-select codes,
// and a one-hot check helper for the arbiter's slave select.
package axi_wr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AW   = 2'd1,
        W    = 2'd2,
        B    = 2'd3
    } wr_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] SEL_S0 = 3'b001;
    localparam logic [2:0] SEL_S1 = 3'b010;
    localparam logic [2:0] SEL_DS = 3'b100;

    // True when the select names exactly one known slave.
    function automatic logic sel_is_onehot(input logic [2:0] sel);
        return (sel == SEL_S0) || (sel == SEL_S1) || (sel == SEL_DS);
    endfunction

endpackage

// File: rtl/axi_wr_default_slave.sv
// Internal default slave: accepts AW and W unconditionally (W beats are dropped)
// and answers every unmapped write with DECERR, echoing the latched master AWID.
// Ports: aw_en/w_en/b_en - router is in that phase with DS selected
//        awid_i          - master AWID latched at the AW handshake
//        aw_ready/w_ready/b_valid/b_resp/b_id - DS channel responses
module axi_wr_default_slave
    import axi_wr_pkg::*;
#(
    parameter int unsigned MID_W = 4
) (
    input  logic             aw_en,
    input  logic             w_en,
    input  logic             b_en,
    input  logic [MID_W-1:0] awid_i,
    output logic             aw_ready,
    output logic             w_ready,
    output logic             b_valid,
    output logic [1:0]       b_resp,
    output logic [MID_W-1:0] b_id
);

    assign aw_ready = aw_en;
    assign w_ready  = w_en;
    assign b_valid  = b_en;
    assign b_resp   = b_en ? RESP_DECERR : RESP_OKAY;
    assign b_id     = b_en ? awid_i : '0;

endmodule

// File: rtl/axi_write_router.sv
// Write-path router behind the write arbiter. Latches the grant (master + one-hot
// slave), then steps AW -> W -> B, forwarding the granted master's channels to S0,
// S1 or the internal DECERR default slave. Grant changes outside IDLE are ignored.
// Ports: ACLK/ARESETn (sync active-low), grant_state/grant_sel from the arbiter,
//        full AW/W/B channels for masters M0/M1 and slaves S0/S1.
//        Slave-side IDs are {master bit, slave one-hot, master AWID}.
// Option: define AXI_WR_TIMEOUT_EN to add a B-wait watchdog answering SLVERR
//         after TIMEOUT_CYC cycles without slave BVALID.
module axi_write_router
    import axi_wr_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MID_W       = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [1:0]          grant_state,
    input  logic [3:0]          grant_sel,
    // master 0
    input  logic [MID_W-1:0]    AWID_M0,
    input  logic [ADDR_W-1:0]   AWADDR_M0,
    input  logic [3:0]          AWLEN_M0,
    input  logic [2:0]          AWSIZE_M0,
    input  logic [1:0]          AWBURST_M0,
    input  logic                AWVALID_M0,
    output logic                AWREADY_M0,
    input  logic [DATA_W-1:0]   WDATA_M0,
    input  logic [DATA_W/8-1:0] WSTRB_M0,
    input  logic                WLAST_M0,
    input  logic                WVALID_M0,
    output logic                WREADY_M0,
    output logic [MID_W-1:0]    BID_M0,
    output logic [1:0]          BRESP_M0,
    output logic                BVALID_M0,
    input  logic                BREADY_M0,
    // master 1
    input  logic [MID_W-1:0]    AWID_M1,
    input  logic [ADDR_W-1:0]   AWADDR_M1,
    input  logic [3:0]          AWLEN_M1,
    input  logic [2:0]          AWSIZE_M1,
    input  logic [1:0]          AWBURST_M1,
    input  logic                AWVALID_M1,
    output logic                AWREADY_M1,
    input  logic [DATA_W-1:0]   WDATA_M1,
    input  logic [DATA_W/8-1:0] WSTRB_M1,
    input  logic                WLAST_M1,
    input  logic                WVALID_M1,
    output logic                WREADY_M1,
    output logic [MID_W-1:0]    BID_M1,
    output logic [1:0]          BRESP_M1,
    output logic                BVALID_M1,
    input  logic                BREADY_M1,
    // slave 0
    output logic [MID_W+3:0]    AWID_S0,
    output logic [ADDR_W-1:0]   AWADDR_S0,
    output logic [3:0]          AWLEN_S0,
    output logic [2:0]          AWSIZE_S0,
    output logic [1:0]          AWBURST_S0,
    output logic                AWVALID_S0,
    input  logic                AWREADY_S0,
    output logic [DATA_W-1:0]   WDATA_S0,
    output logic [DATA_W/8-1:0] WSTRB_S0,
    output logic                WLAST_S0,
    output logic                WVALID_S0,
    input  logic                WREADY_S0,
    input  logic [MID_W+3:0]    BID_S0,
    input  logic [1:0]          BRESP_S0,
    input  logic                BVALID_S0,
    output logic                BREADY_S0,
    // slave 1
    output logic [MID_W+3:0]    AWID_S1,
    output logic [ADDR_W-1:0]   AWADDR_S1,
    output logic [3:0]          AWLEN_S1,
    output logic [2:0]          AWSIZE_S1,
    output logic [1:0]          AWBURST_S1,
    output logic                AWVALID_S1,
    input  logic                AWREADY_S1,
    output logic [DATA_W-1:0]   WDATA_S1,
    output logic [DATA_W/8-1:0] WSTRB_S1,
    output logic                WLAST_S1,
    output logic                WVALID_S1,
    input  logic                WREADY_S1,
    input  logic [MID_W+3:0]    BID_S1,
    input  logic [1:0]          BRESP_S1,
    input  logic                BVALID_S1,
    output logic                BREADY_S1
);

    localparam int unsigned SID_W = MID_W + 4;

    wr_state_e        state_q, state_d;
    logic             mst_q, mst_d;
    logic [2:0]       sel_q, sel_d;
    logic [MID_W-1:0] awid_q, awid_d;
    logic [3:0]       awlen_q, awlen_d;
    logic [4:0]       beat_q, beat_d;

    logic st_aw, st_w, st_b, is_s0, is_s1, is_ds;
    assign st_aw = (state_q == AW);
    assign st_w  = (state_q == W);
    assign st_b  = (state_q == B);
    assign is_s0 = (sel_q == SEL_S0);
    assign is_s1 = (sel_q == SEL_S1);
    assign is_ds = !is_s0 && !is_s1;

    // Granted-master view of the master channels.
    logic                m_awvalid, m_wvalid, m_wlast, m_bready;
    logic [MID_W-1:0]    m_awid;
    logic [ADDR_W-1:0]   m_awaddr;
    logic [3:0]          m_awlen;
    logic [2:0]          m_awsize;
    logic [1:0]          m_awburst;
    logic [DATA_W-1:0]   m_wdata;
    logic [DATA_W/8-1:0] m_wstrb;
    assign m_awvalid = mst_q ? AWVALID_M1 : AWVALID_M0;
    assign m_awid    = mst_q ? AWID_M1    : AWID_M0;
    assign m_awaddr  = mst_q ? AWADDR_M1  : AWADDR_M0;
    assign m_awlen   = mst_q ? AWLEN_M1   : AWLEN_M0;
    assign m_awsize  = mst_q ? AWSIZE_M1  : AWSIZE_M0;
    assign m_awburst = mst_q ? AWBURST_M1 : AWBURST_M0;
    assign m_wvalid  = mst_q ? WVALID_M1  : WVALID_M0;
    assign m_wdata   = mst_q ? WDATA_M1   : WDATA_M0;
    assign m_wstrb   = mst_q ? WSTRB_M1   : WSTRB_M0;
    assign m_wlast   = mst_q ? WLAST_M1   : WLAST_M0;
    assign m_bready  = mst_q ? BREADY_M1  : BREADY_M0;

    logic [SID_W-1:0] slv_awid;
    assign slv_awid = {mst_q, sel_q, m_awid};

    // Default slave
    logic             ds_awready, ds_wready, ds_bvalid;
    logic [1:0]       ds_bresp;
    logic [MID_W-1:0] ds_bid;

    axi_wr_default_slave #(.MID_W(MID_W)) u_ds (
        .aw_en    (st_aw && is_ds),
        .w_en     (st_w && is_ds),
        .b_en     (st_b && is_ds),
        .awid_i   (awid_q),
        .aw_ready (ds_awready),
        .w_ready  (ds_wready),
        .b_valid  (ds_bvalid),
        .b_resp   (ds_bresp),
        .b_id     (ds_bid)
    );

    // Selected-slave view of the slave responses.
    logic             s_awready, s_wready, s_bvalid_raw;
    logic [1:0]       s_bresp_raw;
    logic [MID_W-1:0] s_bid_raw;
    always_comb begin
        s_awready    = ds_awready;
        s_wready     = ds_wready;
        s_bvalid_raw = ds_bvalid;
        s_bresp_raw  = ds_bresp;
        s_bid_raw    = ds_bid;
        if (is_s0) begin
            s_awready    = AWREADY_S0;
            s_wready     = WREADY_S0;
            s_bvalid_raw = BVALID_S0;
            s_bresp_raw  = BRESP_S0;
            s_bid_raw    = BID_S0[MID_W-1:0];
        end else if (is_s1) begin
            s_awready    = AWREADY_S1;
            s_wready     = WREADY_S1;
            s_bvalid_raw = BVALID_S1;
            s_bresp_raw  = BRESP_S1;
            s_bid_raw    = BID_S1[MID_W-1:0];
        end
    end

    // B-wait watchdog: once expired, the router answers SLVERR itself.
    logic tmo_hit;
`ifdef AXI_WR_TIMEOUT_EN
    logic [7:0] tmo_q, tmo_d;
    assign tmo_hit = st_b && (tmo_q == 8'(TIMEOUT_CYC));
`else
    assign tmo_hit = 1'b0;
`endif

    logic             s_bvalid;
    logic [1:0]       s_bresp;
    logic [MID_W-1:0] s_bid;
    assign s_bvalid = tmo_hit || s_bvalid_raw;
    assign s_bresp  = tmo_hit ? RESP_SLVERR : s_bresp_raw;
    assign s_bid    = tmo_hit ? awid_q : s_bid_raw;

    logic aw_hs, w_hs, b_hs;
    assign aw_hs = st_aw && m_awvalid && s_awready;
    assign w_hs  = st_w && m_wvalid && s_wready;
    assign b_hs  = st_b && s_bvalid && m_bready;

    // Next-state and latched-grant logic.
    always_comb begin
        state_d = state_q;
        mst_d   = mst_q;
        sel_d   = sel_q;
        awid_d  = awid_q;
        awlen_d = awlen_q;
        beat_d  = beat_q;
`ifdef AXI_WR_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        unique case (state_q)
            IDLE: begin
                // 2'b11 is not a valid owner and is treated as idle.
                if (grant_state == 2'b01 || grant_state == 2'b10) begin
                    mst_d   = grant_state[1];
                    sel_d   = sel_is_onehot(grant_sel[2:0]) ? grant_sel[2:0] : SEL_DS;
                    state_d = AW;
                end
            end
            AW: begin
                if (aw_hs) begin
                    awid_d  = m_awid;
                    awlen_d = m_awlen;
                    beat_d  = '0;
                    state_d = W;
                end
            end
            W: begin
                if (w_hs) begin
                    beat_d = beat_q + 5'd1;
                    if (m_wlast) begin
                        state_d = B;
`ifdef AXI_WR_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end
                end
            end
            B: begin
`ifdef AXI_WR_TIMEOUT_EN
                if (!s_bvalid_raw && !tmo_hit) tmo_d = tmo_q + 8'd1;
`endif
                if (b_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            mst_q   <= 1'b0;
            sel_q   <= '0;
            awid_q  <= '0;
            awlen_q <= '0;
            beat_q  <= '0;
`ifdef AXI_WR_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            mst_q   <= mst_d;
            sel_q   <= sel_d;
            awid_q  <= awid_d;
            awlen_q <= awlen_d;
            beat_q  <= beat_d;
`ifdef AXI_WR_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    // Slave-side forwarding; payloads are zero unless that slave is in the phase.
    logic fwd_aw_s0, fwd_aw_s1, fwd_w_s0, fwd_w_s1;
    assign fwd_aw_s0 = st_aw && is_s0;
    assign fwd_aw_s1 = st_aw && is_s1;
    assign fwd_w_s0  = st_w && is_s0;
    assign fwd_w_s1  = st_w && is_s1;

    assign AWVALID_S0 = fwd_aw_s0 && m_awvalid;
    assign AWID_S0    = fwd_aw_s0 ? slv_awid  : '0;
    assign AWADDR_S0  = fwd_aw_s0 ? m_awaddr  : '0;
    assign AWLEN_S0   = fwd_aw_s0 ? m_awlen   : '0;
    assign AWSIZE_S0  = fwd_aw_s0 ? m_awsize  : '0;
    assign AWBURST_S0 = fwd_aw_s0 ? m_awburst : '0;
    assign WVALID_S0  = fwd_w_s0 && m_wvalid;
    assign WDATA_S0   = fwd_w_s0 ? m_wdata : '0;
    assign WSTRB_S0   = fwd_w_s0 ? m_wstrb : '0;
    assign WLAST_S0   = fwd_w_s0 && m_wlast;
    assign BREADY_S0  = st_b && is_s0 && m_bready && !tmo_hit;

    assign AWVALID_S1 = fwd_aw_s1 && m_awvalid;
    assign AWID_S1    = fwd_aw_s1 ? slv_awid  : '0;
    assign AWADDR_S1  = fwd_aw_s1 ? m_awaddr  : '0;
    assign AWLEN_S1   = fwd_aw_s1 ? m_awlen   : '0;
    assign AWSIZE_S1  = fwd_aw_s1 ? m_awsize  : '0;
    assign AWBURST_S1 = fwd_aw_s1 ? m_awburst : '0;
    assign WVALID_S1  = fwd_w_s1 && m_wvalid;
    assign WDATA_S1   = fwd_w_s1 ? m_wdata : '0;
    assign WSTRB_S1   = fwd_w_s1 ? m_wstrb : '0;
    assign WLAST_S1   = fwd_w_s1 && m_wlast;
    assign BREADY_S1  = st_b && is_s1 && m_bready && !tmo_hit;

    // Master-side responses go to the granted master only.
    assign AWREADY_M0 = st_aw && !mst_q && s_awready;
    assign WREADY_M0  = st_w && !mst_q && s_wready;
    assign BVALID_M0  = st_b && !mst_q && s_bvalid;
    assign BRESP_M0   = (st_b && !mst_q) ? s_bresp : '0;
    assign BID_M0     = (st_b && !mst_q) ? s_bid : '0;

    assign AWREADY_M1 = st_aw && mst_q && s_awready;
    assign WREADY_M1  = st_w && mst_q && s_wready;
    assign BVALID_M1  = st_b && mst_q && s_bvalid;
    assign BRESP_M1   = (st_b && mst_q) ? s_bresp : '0;
    assign BID_M1     = (st_b && mst_q) ? s_bid : '0;

    // Burst-length mismatch is tolerated (WLAST governs); flag kept as a debug probe.
    logic len_mismatch_c;
    assign len_mismatch_c = w_hs && (m_wlast != (beat_q == {1'b0, awlen_q}));

    logic unused_c;
`ifdef AXI_WR_TIMEOUT_EN
    assign unused_c = ^{grant_sel[3], BID_S0[SID_W-1:MID_W], BID_S1[SID_W-1:MID_W], len_mismatch_c};
`else
    assign unused_c = ^{grant_sel[3], BID_S0[SID_W-1:MID_W], BID_S1[SID_W-1:MID_W], len_mismatch_c,
                        32'(TIMEOUT_CYC)};
`endif

endmodule
